// File: rtl/axi_sram_bridge_if.sv
// AXI3-style bus between the core_top master and the SRAM bridge.
// Holds the five channels (AR, R, AW, W, B); clock and reset stay outside.
interface axi_sram_bridge_if;
    // read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    // read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    // write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    // write data channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_sram_bridge.sv
// AXI slave to single-port synchronous SRAM bridge.
// One transaction in flight; writes win over simultaneous reads.
// SRAM read data appears one cycle after ram_en with ram_we == 0.
module axi_sram_bridge #(
    parameter int unsigned RAM_AW = 20
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_sram_bridge_if.slave  axi,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state;
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic [7:0]  beat_q;
    logic        wlast_err_q;

    logic        aw_hs;
    logic        ar_hs;
    logic        w_hs;
    logic        r_hs;
    logic        b_hs;
    logic        beat_last;
    logic        burst_rsvd;
    logic [31:0] next_addr;

    // Address of the following beat: INCR steps, FIXED holds, WRAP folds
    // back inside the (len+1)<<size aligned window; reserved bursts hold.
    function automatic logic [31:0] next_beat_addr(
        input logic [31:0] a,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] win_mask;
        step     = 32'd1 << size;
        win_mask = ((32'(len) + 32'd1) << size) - 32'd1;
        case (burst)
            2'b01:   return a + step;
            2'b10:   return (a & ~win_mask) | ((a + step) & win_mask);
            default: return a;
        endcase
    endfunction

    // Ready signals decode the state directly so the handshake completes
    // in the cycle the request is presented; held low while in reset.
    assign axi.awready = (state == IDLE) && axi.awvalid && aresetn;
    assign axi.arready = (state == IDLE) && axi.arvalid && !axi.awvalid && aresetn;
    assign axi.wready  = (state == WR_DATA);

    assign aw_hs = axi.awvalid && axi.awready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign r_hs  = axi.rvalid && axi.rready;
    assign b_hs  = axi.bvalid && axi.bready;

    assign beat_last  = (beat_q == len_q);
    assign burst_rsvd = (burst_q == 2'b11);
    assign next_addr  = next_beat_addr(addr_q, len_q, size_q, burst_q);

    // SRAM port: one read strobe in RD_REQ, one write strobe per W handshake.
    // Reserved-burst writes keep the strobe but never enable byte lanes.
    assign ram_en    = (state == RD_REQ) || w_hs;
    assign ram_we    = (w_hs && !burst_rsvd) ? axi.wstrb : '0;
    assign ram_wdata = w_hs ? axi.wdata : '0;
    assign ram_addr  = addr_q[RAM_AW-1:2];

    // Transaction FSM with registered R and B channel outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beat_q      <= '0;
            wlast_err_q <= 1'b0;
            axi.rid     <= '0;
            axi.rdata   <= '0;
            axi.rresp   <= '0;
            axi.rlast   <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= '0;
            axi.bvalid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        id_q        <= axi.awid;
                        addr_q      <= axi.awaddr;
                        len_q       <= axi.awlen;
                        size_q      <= axi.awsize;
                        burst_q     <= axi.awburst;
                        beat_q      <= '0;
                        wlast_err_q <= 1'b0;
                        state       <= WR_DATA;
                    end else if (ar_hs) begin
                        id_q    <= axi.arid;
                        addr_q  <= axi.araddr;
                        len_q   <= axi.arlen;
                        size_q  <= axi.arsize;
                        burst_q <= axi.arburst;
                        beat_q  <= '0;
                        state   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    axi.rdata  <= ram_rdata;
                    axi.rid    <= id_q;
                    axi.rresp  <= burst_rsvd ? RESP_SLVERR : RESP_OKAY;
                    axi.rlast  <= beat_last;
                    axi.rvalid <= 1'b1;
                    state      <= RD_DATA;
                end
                RD_DATA: begin
                    if (r_hs) begin
                        axi.rvalid <= 1'b0;
                        axi.rlast  <= 1'b0;
                        if (axi.rlast) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                            state  <= RD_REQ;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        if (beat_last) begin
                            axi.bid    <= id_q;
                            axi.bresp  <= (burst_rsvd || wlast_err_q || !axi.wlast)
                                          ? RESP_SLVERR : RESP_OKAY;
                            axi.bvalid <= 1'b1;
                            state      <= WR_RESP;
                        end else begin
                            if (axi.wlast) begin
                                wlast_err_q <= 1'b1;
                            end
                            addr_q <= next_addr;
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        axi.bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge: behavioural SRAM, scoreboard queues
// for R beats and B responses, immediate assertions at every check point.
module tb_axi_sram_bridge;

    localparam int unsigned AW = 12;
    localparam int unsigned WORDS = 1 << (AW - 2);

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic        chk_data;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic          aclk;
    logic          aresetn;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-3:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0] mem [0:WORDS-1];
    rexp_t       rq[$];
    bexp_t       bq[$];

    int cyc        = 0;
    int ram_en_cnt = 0;
    int n_cmp      = 0;
    int n_fail     = 0;

    axi_sram_bridge_if axi();

    axi_sram_bridge #(.RAM_AW(AW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .axi       (axi),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // cycle counter and synchronous SRAM with byte enables
    always @(posedge aclk) begin
        cyc++;
        if (ram_en) begin
            ram_en_cnt++;
            if (ram_we == 4'd0) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int k = 0; k < 4; k++)
                    if (ram_we[k]) mem[ram_addr][8*k +: 8] = ram_wdata[8*k +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output int hs);
        int w;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
        axi.arburst = burst; axi.arvalid = 1'b1;
        #1; w = 0;
        while (!axi.arready && w < 100) begin @(negedge aclk); #1; w++; end
        if (!axi.arready) check("ar_timeout", 32'd0, 32'd1);
        @(negedge aclk);
        axi.arvalid = 1'b0;
        hs = cyc;
    endtask

    task automatic aw_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        int w;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2;
        axi.awburst = burst; axi.awvalid = 1'b1;
        #1; w = 0;
        while (!axi.awready && w < 100) begin @(negedge aclk); #1; w++; end
        if (!axi.awready) check("aw_timeout", 32'd0, 32'd1);
        @(negedge aclk);
        axi.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int w;
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        #1; w = 0;
        while (!axi.wready && w < 100) begin @(negedge aclk); #1; w++; end
        if (!axi.wready) check("w_timeout", 32'd0, 32'd1);
        @(negedge aclk);
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
    endtask

    task automatic b_collect();
        int w;
        bexp_t e;
        axi.bready = 1'b1; w = 0;
        while (!axi.bvalid && w < 100) begin @(negedge aclk); w++; end
        if (!axi.bvalid) begin
            check("b_timeout", 32'd0, 32'd1);
            axi.bready = 1'b0;
            return;
        end
        if (bq.size() == 0) begin
            check("b_unexpected", 32'd1, 32'd0);
        end else begin
            e = bq.pop_front();
            check("bid", 32'(axi.bid), 32'(e.id));
            check("bresp", 32'(axi.bresp), 32'(e.resp));
        end
        @(negedge aclk);
        axi.bready = 1'b0;
        check("bvalid_drop", 32'(axi.bvalid), 32'd0);
    endtask

    // Collects n R beats; hold = cycles rready stays low on the first beat.
    task automatic read_beats(input int n, input int hold, input int hs);
        int w;
        int last_hs;
        rexp_t e;
        logic [31:0] held;
        last_hs = hs;
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (!axi.rvalid && w < 100) begin @(negedge aclk); w++; end
            if (!axi.rvalid) begin
                check("r_timeout", 32'd0, 32'd1);
                return;
            end
            check("r_latency", 32'(cyc), 32'(last_hs + 2));
            if (rq.size() == 0) begin
                check("r_unexpected", 32'd1, 32'd0);
                return;
            end
            e = rq.pop_front();
            if (e.chk_data) check("rdata", axi.rdata, e.data);
            check("rid", 32'(axi.rid), 32'(e.id));
            check("rresp", 32'(axi.rresp), 32'(e.resp));
            check("rlast", 32'(axi.rlast), 32'(e.last));
            held = axi.rdata;
            if (b == 0) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge aclk);
                    check("r_hold_valid", 32'(axi.rvalid), 32'd1);
                    check("r_hold_data", axi.rdata, held);
                end
            end
            axi.rready = 1'b1;
            @(negedge aclk);
            axi.rready = 1'b0;
            last_hs = cyc;
            check("rvalid_drop", 32'(axi.rvalid), 32'd0);
        end
    endtask

    initial begin
        int    hs;
        int    en_snap;
        bexp_t be;

        for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'd0;
        mem[10'h040] = 32'hDEADBEEF;
        mem[10'h041] = 32'h11111111;
        mem[10'h042] = 32'h22222222;
        mem[10'h043] = 32'h33333333;
        mem[10'h0C0] = 32'h12345678;

        aresetn = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.rready = 1'b0; axi.bready = 1'b0;
        axi.arvalid = 1'b1; axi.awvalid = 1'b1;

        // reset state, with requests pending
        @(negedge aclk); @(negedge aclk); #1;
        check("rst_awready", 32'(axi.awready), 32'd0);
        check("rst_arready", 32'(axi.arready), 32'd0);
        check("rst_wready", 32'(axi.wready), 32'd0);
        check("rst_rvalid", 32'(axi.rvalid), 32'd0);
        check("rst_bvalid", 32'(axi.bvalid), 32'd0);
        check("rst_rlast", 32'(axi.rlast), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_rdata", axi.rdata, 32'd0);
        check("rst_ids", {24'd0, axi.rid, axi.bid}, 32'd0);
        check("rst_resps", {28'd0, axi.rresp, axi.bresp}, 32'd0);
        axi.arvalid = 1'b0; axi.awvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // single INCR read
        rq.push_back('{32'hDEADBEEF, 4'd3, 2'b00, 1'b1, 1'b1});
        ar_issue(4'd3, 32'h100, 8'd0, 3'd2, 2'b01, hs);
        read_beats(1, 0, hs);

        // INCR write burst of four words
        bq.push_back('{4'd5, 2'b00});
        aw_issue(4'd5, 32'h200, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) w_beat(32'(i + 1), 4'hF, i == 3);
        b_collect();
        for (int i = 0; i < 4; i++) check("wr_incr_mem", mem[10'h080 + i], 32'(i + 1));

        // read the burst back
        for (int i = 0; i < 4; i++) rq.push_back('{32'(i + 1), 4'hC, 2'b00, i == 3, 1'b1});
        ar_issue(4'hC, 32'h200, 8'd3, 3'd2, 2'b01, hs);
        read_beats(4, 0, hs);

        // simultaneous AR/AW: write goes first, read waits for the B handshake
        axi.arid = 4'd1; axi.araddr = 32'h300; axi.arlen = 8'd0; axi.arsize = 3'd2;
        axi.arburst = 2'b01; axi.arvalid = 1'b1;
        axi.awid = 4'd7; axi.awaddr = 32'h240; axi.awlen = 8'd0; axi.awsize = 3'd2;
        axi.awburst = 2'b01; axi.awvalid = 1'b1;
        #1;
        check("sim_awready", 32'(axi.awready), 32'd1);
        check("sim_arready_blocked", 32'(axi.arready), 32'd0);
        @(negedge aclk);
        axi.awvalid = 1'b0;
        axi.wdata = 32'h0BADCAFE; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
        #1;
        check("sim_wready", 32'(axi.wready), 32'd1);
        check("sim_ar_in_wr", 32'(axi.arready), 32'd0);
        @(negedge aclk);
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        bq.push_back('{4'd7, 2'b00});
        axi.bready = 1'b1;
        #1;
        check("sim_ar_in_resp", 32'(axi.arready), 32'd0);
        check("sim_bvalid", 32'(axi.bvalid), 32'd1);
        be = bq.pop_front();
        check("sim_bid", 32'(axi.bid), 32'(be.id));
        check("sim_bresp", 32'(axi.bresp), 32'(be.resp));
        @(negedge aclk);
        axi.bready = 1'b0;
        #1;
        check("sim_ar_after_b", 32'(axi.arready), 32'd1);
        @(negedge aclk);
        axi.arvalid = 1'b0;
        hs = cyc;
        rq.push_back('{32'h12345678, 4'd1, 2'b00, 1'b1, 1'b1});
        read_beats(1, 5, hs);
        check("sim_wr_mem", mem[10'h090], 32'h0BADCAFE);

        // WRAP read starting at the last word of a 16-byte window
        rq.push_back('{32'h33333333, 4'd2, 2'b00, 1'b0, 1'b1});
        rq.push_back('{32'hDEADBEEF, 4'd2, 2'b00, 1'b0, 1'b1});
        rq.push_back('{32'h11111111, 4'd2, 2'b00, 1'b0, 1'b1});
        rq.push_back('{32'h22222222, 4'd2, 2'b00, 1'b1, 1'b1});
        ar_issue(4'd2, 32'h10C, 8'd3, 3'd2, 2'b10, hs);
        read_beats(4, 0, hs);

        // FIXED read returns the same word each beat
        rq.push_back('{32'h11111111, 4'hA, 2'b00, 1'b0, 1'b1});
        rq.push_back('{32'h11111111, 4'hA, 2'b00, 1'b1, 1'b1});
        ar_issue(4'hA, 32'h104, 8'd1, 3'd2, 2'b00, hs);
        read_beats(2, 0, hs);

        // early wlast on a two-beat write
        bq.push_back('{4'd8, 2'b10});
        aw_issue(4'd8, 32'h3C0, 8'd1, 2'b01);
        w_beat(32'hA5A5A5A5, 4'hF, 1'b1);
        w_beat(32'h5A5A5A5A, 4'hF, 1'b1);
        b_collect();

        // missing wlast on a single-beat write
        bq.push_back('{4'd9, 2'b10});
        aw_issue(4'd9, 32'h3D0, 8'd0, 2'b01);
        w_beat(32'h01020304, 4'hF, 1'b0);
        b_collect();

        // reserved burst write: SLVERR, memory untouched
        bq.push_back('{4'd6, 2'b10});
        aw_issue(4'd6, 32'h380, 8'd1, 2'b11);
        w_beat(32'hFFFFFFFF, 4'hF, 1'b0);
        w_beat(32'hEEEEEEEE, 4'hF, 1'b1);
        b_collect();
        check("rsvd_wr_mem0", mem[10'h0E0], 32'd0);
        check("rsvd_wr_mem1", mem[10'h0E1], 32'd0);

        // reserved burst read: every beat SLVERR
        rq.push_back('{32'd0, 4'd1, 2'b10, 1'b0, 1'b0});
        rq.push_back('{32'd0, 4'd1, 2'b10, 1'b1, 1'b0});
        ar_issue(4'd1, 32'h100, 8'd1, 3'd2, 2'b11, hs);
        read_beats(2, 0, hs);

        // reset while the third beat of a four-beat write is presented
        aw_issue(4'd9, 32'h280, 8'd3, 2'b01);
        w_beat(32'hAAAA0000, 4'hF, 1'b0);
        w_beat(32'hAAAA0001, 4'hF, 1'b0);
        axi.wdata = 32'hAAAA0002; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        #1;
        check("mid_wready", 32'(axi.wready), 32'd1);
        #1;
        aresetn = 1'b0;
        #1;
        check("mid_rst_wready", 32'(axi.wready), 32'd0);
        check("mid_rst_ram_en", 32'(ram_en), 32'd0);
        check("mid_rst_ram_we", 32'(ram_we), 32'd0);
        check("mid_rst_bvalid", 32'(axi.bvalid), 32'd0);
        @(negedge aclk);
        axi.wvalid = 1'b0;
        en_snap = ram_en_cnt;
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        check("mid_no_ram_en", 32'(ram_en_cnt), 32'(en_snap));
        check("mid_no_bvalid", 32'(axi.bvalid), 32'd0);
        check("mid_mem0", mem[10'h0A0], 32'hAAAA0000);
        check("mid_mem1", mem[10'h0A1], 32'hAAAA0001);
        check("mid_mem2", mem[10'h0A2], 32'd0);

        // next write after the abort, with partial strobes
        bq.push_back('{4'd4, 2'b00});
        aw_issue(4'd4, 32'h2C0, 8'd0, 2'b01);
        w_beat(32'hCAFEF00D, 4'b0011, 1'b1);
        b_collect();
        check("post_rst_mem", mem[10'h0B0], 32'h0000F00D);

        check("rq_empty", 32'(rq.size()), 32'd0);
        check("bq_empty", 32'(bq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
